smi_spram_ctrl: RTL
===================

# smi_spram_ctrl

- Bridges the Pi SMI secondary-memory bus to one 16K×16 SPRAM used as a sample ring buffer.
- An internal producer pushes 16-bit samples; the Pi pops them with SMI reads, reads fill-count and status, and flushes with SMI writes.
- The block owns all SPRAM port arbitration, and all SMI strobe synchronization into the single 48 MHz fabric clock.

## Interface
- DEPTH_LOG2, 14, log2 ring depth in words; ring = 2**DEPTH_LOG2 entries.
- clk  in  1  fabric clock (48 MHz HFOSC); one clock, no other domains.
- rst  in  1  reset, synchronous, active-high.
- smi_sa  in  6  SMI address, async to clk.
- smi_soe  in  1  SMI read strobe, active-low, async.
- smi_swe  in  1  SMI write strobe, active-low, async.
- smi_sd_in  in  16  SMI data from Pi, async.
- smi_sd_out  out  16  data to Pi.
- smi_sd_oe  out  1  output enable for SD pads.
- wr_valid  in  1  producer sample strobe, one-cycle pulse, no backpressure.
- wr_data  in  16  producer sample.
- ram_addr  out  DEPTH_LOG2  SPRAM address.
- ram_wdata  out  16  SPRAM write data.
- ram_we  out  1  SPRAM write enable.
- ram_rdata  in  16  SPRAM read data, valid 1 cycle after address.

## Operation
- **Addresses:** 0x2A DATA (read pops), 0x2B COUNT (read), 0x2C FLAGS (read), 0x2D CTRL (write). Any other address: no side effect, smi_sd_oe stays 0.
- **Pointers and count:**
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap mod 2**DEPTH_LOG2.
  - count is DEPTH_LOG2+1 bits, range 0..16384.
  - full = (count == 2**DEPTH_LOG2).
- **Producer:**
  - On wr_valid with !full: ram_we=1, ram_addr=wr_ptr, ram_wdata=wr_data that cycle; wr_ptr++, count++.
  - On wr_valid with full: the sample is dropped and sticky flag ovf is set.
  - Writes always win the RAM port.
- **Head prefetch FSM:**
  - IDLE: head invalid. Go to FETCH when count≠0.
  - FETCH: drive ram_addr=rd_ptr, ram_we=0. If wr_valid is high this cycle, the write takes the port and the FSM stays in FETCH.
  - CAPTURE: head_reg<=ram_rdata, then go to READY.
  - READY: head valid. On a DATA pop: rd_ptr++, count--, go to FETCH if new count≠0, else IDLE.
- **SMI read:**
  - On synced SOE fall, latch the response into out_reg from the address: DATA→head_reg (0x0000 if head invalid), COUNT→{0, count}, FLAGS→{14'b0, udr, ovf}.
  - smi_sd_oe=1 from that latch until synced SOE rise.
  - The pop happens on synced SOE rise, only if the address was DATA and head was valid at the latch.
  - A DATA read with head invalid sets sticky udr and does not pop.
- **SMI write:**
  - Register smi_sd_in every cycle while synced SWE is low.
  - On synced SWE rise with address CTRL:
    - bit0 flush: pointers and count go to 0, FSM to IDLE, flags cleared.
    - bit1 clrflags: ovf and udr cleared.
- **Simultaneous events:**
  - flush and wr_valid in the same cycle: flush wins, the sample is discarded.
  - pop and write in the same cycle: count is unchanged, both pointers advance.
  - ovf/udr set and clrflags in the same cycle: set wins.
- **Address sampling:** smi_sa is sampled through the same 2FF stage as the strobes and held (registered) at the strobe fall edge.

## Timing
- **Reset values:** smi_sd_out=0, smi_sd_oe=0, ram_we=0, ram_addr=0, ram_wdata=0, pointers and count=0, flags=0, FSM=IDLE, out_reg=0.
- **Strobe sync:** 2FF synchronizer plus edge detect; an edge is seen 2–3 clk after the pad edge.
- **Read latency:** SOE fall → smi_sd_out valid in ≤4 clk (≤83 ns). Pi SMI read setup+strobe must be configured ≥100 ns; hold ≥3 clk after SOE rise.
- **Refill:** after a pop, head is valid again 3 clk later when no writes intervene; each wr_valid cycle adds 1 clk. Back-to-back DATA reads need a strobe period ≥ 8 clk.
- **Write capture:** SWE data must be stable for ≥3 clk before SWE rise.

## Structure
- **Package smi_pkg:** address constants (ADDR_DATA, ADDR_COUNT, ADDR_FLAGS, ADDR_CTRL), CTRL/FLAGS bit indices, and the FSM state enum (IDLE, FETCH, CAPTURE, READY).
- **Sub-module smi_strobe_sync:** 2FF synchronizer with rise/fall pulse outputs, instantiated for SOE and SWE.
- The SPRAM primitive (SB_SPRAM256KA) is instantiated by the parent, not here.

## Test plan
- **Fill/drain:** reset, push 0x0001..0x0010, then 16 DATA reads → 0x0001..0x0010 in order; a COUNT read then returns 0x0000.
- **Underrun:** DATA read on an empty ring → 0x0000, no pointer change; FLAGS read → 0x0002.
- **Overflow:** push 16385 samples → COUNT reads 0x4000, FLAGS reads 0x0001; the first DATA read returns the first sample.
- **Contention:** wr_valid held on alternate cycles during 8 back-to-back pops (8-clk strobe period) → no lost or duplicated words; count is consistent.
- **Flush race:** CTRL write 0x0001 coincident with wr_valid → COUNT reads 0, FLAGS reads 0; the next pushed sample is the first returned.
- **Reset mid-read:** assert rst while SOE is low → smi_sd_oe=0 next cycle, all state is reset; no pop occurs on the later SOE rise.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared definitions for the SMI-to-SPRAM sample ring bridge: register
// addresses, CTRL/FLAGS bit positions and the head prefetch state encoding.
package smi_pkg;

  localparam logic [5:0] ADDR_DATA  = 6'h2A;
  localparam logic [5:0] ADDR_COUNT = 6'h2B;
  localparam logic [5:0] ADDR_FLAGS = 6'h2C;
  localparam logic [5:0] ADDR_CTRL  = 6'h2D;

  localparam int CTRL_FLUSH    = 0;
  localparam int CTRL_CLRFLAGS = 1;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UDR = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } head_state_t;

endpackage

// File: rtl/smi_strobe_sync.sv
// Two-flop synchronizer for an asynchronous active-low SMI strobe, with a
// third stage so single-cycle rise and fall pulses can be derived.
module smi_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Resampling chain; reset to the asserted (low) level so a strobe already
  // low when reset releases cannot produce a fall pulse, and the spurious
  // rise seen when it is high finds nothing pending.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbour and the chain never collapses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/smi_spram_ctrl.sv
// Bridges the Pi SMI secondary-memory bus to a single-port SPRAM used as a
// sample ring. The fabric producer writes samples; the Pi pops the head word,
// reads count/flags and flushes, all through resynchronised SMI strobes.
module smi_spram_ctrl
  import smi_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            smi_sa,
  input  logic                  smi_soe,
  input  logic                  smi_swe,
  input  logic [15:0]           smi_sd_in,
  output logic [15:0]           smi_sd_out,
  output logic                  smi_sd_oe,
  input  logic                  wr_valid,
  input  logic [15:0]           wr_data,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  output logic                  ram_we,
  input  logic [15:0]           ram_rdata
);

  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // Strobe synchronisation
  logic soe_level, soe_rise, soe_fall;
  logic swe_level, swe_rise, swe_fall;

  smi_strobe_sync u_soe_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (smi_soe),
    .level  (soe_level),
    .rise   (soe_rise),
    .fall   (soe_fall)
  );

  smi_strobe_sync u_swe_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (smi_swe),
    .level  (swe_level),
    .rise   (swe_rise),
    .fall   (swe_fall)
  );

  // Ring and SMI interface state
  logic [5:0]            sa_s1, sa_s2;
  logic [5:0]            wr_addr;
  logic [15:0]           ctrl_data;
  logic [15:0]           out_reg;
  logic                  oe_reg;
  logic                  pop_pending;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_next;
  logic                  ovf, udr;
  logic [15:0]           head_reg;
  head_state_t           state, state_next;

  logic full, head_valid;
  logic do_flush, do_clr, do_write, do_pop;
  logic ovf_set, udr_set;

  // Only the two low CTRL bits carry commands; the rest are reserved.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^ctrl_data[15:2];

  assign full       = (count == COUNT_FULL);
  assign head_valid = (state == READY);

  assign do_flush = swe_rise && (wr_addr == ADDR_CTRL) && ctrl_data[CTRL_FLUSH];
  assign do_clr   = swe_rise && (wr_addr == ADDR_CTRL) && ctrl_data[CTRL_CLRFLAGS];
  assign do_write = wr_valid && !full && !do_flush;
  assign do_pop   = soe_rise && pop_pending && head_valid && !do_flush;
  assign ovf_set  = wr_valid && full && !do_flush;
  assign udr_set  = soe_fall && (sa_s2 == ADDR_DATA) && !head_valid;

  assign smi_sd_out = out_reg;
  assign smi_sd_oe  = oe_reg;

  // Next count, head prefetch transitions and SPRAM port ownership
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    state_next = state;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;

    if (do_write && !do_pop)      count_next = count + COUNT_ONE;
    else if (do_pop && !do_write) count_next = count - COUNT_ONE;
    if (do_flush)                 count_next = '0;

    case (state)
      IDLE:    if (count != '0) state_next = FETCH;
      FETCH:   if (!wr_valid)   state_next = CAPTURE;
      CAPTURE: state_next = READY;
      READY:   if (do_pop) state_next = (count_next != '0) ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
    if (do_flush) state_next = IDLE;

    // The producer has no backpressure, so it always owns the port when it
    // strobes; the prefetch read simply retries next cycle.
    if (!rst) begin
      if (wr_valid) begin
        ram_addr  = wr_ptr;
        ram_wdata = wr_data;
        ram_we    = do_write;
      end else if (state == FETCH) begin
        ram_addr = rd_ptr;
      end
    end
  end

  // Ring pointers, count, sticky flags, head register and prefetch state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      udr      <= 1'b0;
      head_reg <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (do_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)   rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A new event in the same cycle as a clear must not be lost.
      ovf <= (ovf & ~(do_clr | do_flush)) | ovf_set;
      udr <= (udr & ~(do_clr | do_flush)) | udr_set;
      if (state == CAPTURE) head_reg <= ram_rdata;
    end
  end

  // SMI address sync, read response latch, output enable and write capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_s1       <= '0;
      sa_s2       <= '0;
      wr_addr     <= '0;
      ctrl_data   <= '0;
      out_reg     <= '0;
      oe_reg      <= 1'b0;
      pop_pending <= 1'b0;
    end else begin
      sa_s1 <= smi_sa;
      sa_s2 <= sa_s1;

      if (soe_fall) begin
        case (sa_s2)
          ADDR_DATA: begin
            out_reg     <= head_valid ? head_reg : 16'h0000;
            oe_reg      <= 1'b1;
            pop_pending <= head_valid;
          end
          ADDR_COUNT: begin
            out_reg     <= 16'(count);
            oe_reg      <= 1'b1;
            pop_pending <= 1'b0;
          end
          ADDR_FLAGS: begin
            out_reg                <= '0;
            out_reg[FLAG_OVF]      <= ovf;
            out_reg[FLAG_UDR]      <= udr;
            oe_reg                 <= 1'b1;
            pop_pending            <= 1'b0;
          end
          default: pop_pending <= 1'b0;
        endcase
      end else if (soe_level) begin
        oe_reg      <= 1'b0;
        pop_pending <= 1'b0;
      end
      if (do_flush) pop_pending <= 1'b0;

      if (!swe_level) ctrl_data <= smi_sd_in;
      if (swe_fall)   wr_addr   <= sa_s2;
    end
  end

endmodule
